// File: rtl/muldiv_sequencer_if.sv
// Handshake/operand bundle between the execute stage and the iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [3:0]        alu_ctrl;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              flush;
   logic              stall;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] result_hi;
   logic              div_by_zero;

   modport master (
      output start, alu_ctrl, op_a, op_b, flush,
      input  stall, busy, done, result, result_hi, div_by_zero
   );

   modport slave (
      input  start, alu_ctrl, op_a, op_b, flush,
      output stall, busy, done, result, result_hi, div_by_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider taking DATA_W cycles, stalling the pipeline meanwhile.
// Define MULDIV_SIGNED_EN for two's-complement operands (magnitude datapath plus final sign fix-up).
module muldiv_sequencer #(
   parameter int DATA_W = 8
) (
   input logic               clk,
   input logic               rst_n,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_is_div;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_mq;
   logic [DATA_W-1:0] r_opnd;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_result_hi;
   logic              r_dbz;

   logic              w_is_mul, w_is_div, w_accept, w_dbz_req;
   logic [DATA_W-1:0] w_a_mag, w_b_mag;
   logic [DATA_W:0]   w_sum, w_shift, w_trial;
   logic [DATA_W-1:0] w_acc_nxt, w_mq_nxt, w_fin_lo, w_fin_hi;

   assign w_is_mul  = (bus.alu_ctrl == 4'b1010);
   assign w_is_div  = (bus.alu_ctrl == 4'b1011);
   assign w_accept  = rst_n & bus.start & (w_is_mul | w_is_div) & ~bus.flush & (r_state != S_RUN);
   assign w_dbz_req = w_is_div & (bus.op_b == '0);

`ifdef MULDIV_SIGNED_EN
   logic r_neg_res, r_neg_rem;
   assign w_a_mag = bus.op_a[DATA_W-1] ? -bus.op_a : bus.op_a;
   assign w_b_mag = bus.op_b[DATA_W-1] ? -bus.op_b : bus.op_b;
`else
   assign w_a_mag = bus.op_a;
   assign w_b_mag = bus.op_b;
`endif

   assign bus.stall       = (r_state == S_RUN) | w_accept;
   assign bus.busy        = (r_state == S_RUN);
   assign bus.done        = (r_state == S_DONE);
   assign bus.result      = r_result;
   assign bus.result_hi   = r_result_hi;
   assign bus.div_by_zero = r_dbz;

   // One iteration: r_acc is partial-product high half / partial remainder, r_mq is multiplier / quotient.
   always_comb begin
      w_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : '0);
      w_shift = {r_acc, r_mq[DATA_W-1]};
      w_trial = w_shift - {1'b0, r_opnd};
      if (r_is_div) begin
         w_acc_nxt = w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
         w_mq_nxt  = {r_mq[DATA_W-2:0], ~w_trial[DATA_W]};
      end else begin
         w_acc_nxt = w_sum[DATA_W:1];
         w_mq_nxt  = {w_sum[0], r_mq[DATA_W-1:1]};
      end
   end

   always_comb begin
      w_fin_lo = w_mq_nxt;
      w_fin_hi = w_acc_nxt;
`ifdef MULDIV_SIGNED_EN
      if (r_is_div) begin
         if (r_neg_res) w_fin_lo = -w_mq_nxt;
         if (r_neg_rem) w_fin_hi = -w_acc_nxt;
      end else if (r_neg_res) begin
         {w_fin_hi, w_fin_lo} = -{w_acc_nxt, w_mq_nxt};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (bus.flush) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  r_state     <= S_DONE;
                  r_result    <= w_fin_lo;
                  r_result_hi <= w_fin_hi;
                  r_dbz       <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               if (w_accept && w_dbz_req) begin
                  r_state     <= S_DONE;
                  r_result    <= '1;
                  r_result_hi <= bus.op_a;
                  r_dbz       <= 1'b1;
               end else if (w_accept) begin
                  r_state <= S_RUN;
                  r_cnt   <= CW'(DATA_W - 1);
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Working registers carry no reset; they are always loaded on acceptance before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_is_div <= w_is_div;
         r_acc    <= '0;
         r_mq     <= w_is_div ? w_a_mag : w_b_mag;
         r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
`ifdef MULDIV_SIGNED_EN
         r_neg_res <= bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1];
         r_neg_rem <= bus.op_a[DATA_W-1];
`endif
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_nxt;
         r_mq  <= w_mq_nxt;
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic transaction-level reference model.
module tb_muldiv_sequencer;
   localparam int DATA_W = 8;
   localparam int LAT    = DATA_W + 1;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [7:0] exp_lo, exp_hi;
   logic       exp_dz;

   muldiv_sequencer_if #(.DATA_W(DATA_W)) bus ();

   muldiv_sequencer #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model(input bit dv, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] lo, output logic [7:0] hi, output logic dz);
      int sa, sb, p, q, r;
`ifdef MULDIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      dz = 1'b0;
      if (!dv) begin
         p  = sa * sb;
         lo = p[7:0];
         hi = p[15:8];
      end else if (b == 8'h00) begin
         lo = 8'hFF;
         hi = a;
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         lo = q[7:0];
         hi = r[7:0];
      end
   endfunction

   task automatic check_hold(input string tag);
      check({tag, "_res"}, 32'(bus.result), 32'(exp_lo));
      check({tag, "_hi"},  32'(bus.result_hi), 32'(exp_hi));
      check({tag, "_dz"},  32'(bus.div_by_zero), 32'(exp_dz));
   endtask

   // Called a little after a rising edge; leaves the bench a little after a rising edge.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         bus.flush = 1'b0;
         #1;
         check("idle_busy", 32'(bus.busy), 32'd0);
         check("idle_done", 32'(bus.done), 32'd0);
         check("idle_stall", 32'(bus.stall), 32'd0);
         check_hold("idle");
      end
   endtask

   task automatic run_op(input bit dv, input logic [7:0] a, input logic [7:0] b,
                         input int flush_cyc, input bit inj_start);
      logic [7:0] lo, hi;
      logic       dz;
      int         lat;
      model(dv, a, b, lo, hi, dz);
      lat = (dv && b == 8'h00) ? 1 : LAT;
      bus.start    = 1'b1;
      bus.flush    = 1'b0;
      bus.alu_ctrl = dv ? 4'b1011 : 4'b1010;
      bus.op_a     = a;
      bus.op_b     = b;
      #1;
      check("issue_stall", 32'(bus.stall), 32'd1);
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk);
         #1;
         bus.flush    = 1'b0;
         bus.start    = (inj_start && c == 3);
         bus.alu_ctrl = ($urandom_range(0, 1) == 0) ? 4'b1010 : 4'b1011;
         bus.op_a     = 8'($urandom);
         bus.op_b     = 8'($urandom);
         #1;
         if (c == lat) begin
            check("done_pulse", 32'(bus.done), 32'd1);
            check("done_busy", 32'(bus.busy), 32'd0);
            check("done_stall", 32'(bus.stall), 32'd0);
            exp_lo = lo;
            exp_hi = hi;
            exp_dz = dz;
            check_hold("done");
         end else begin
            check("run_busy", 32'(bus.busy), 32'd1);
            check("run_done", 32'(bus.done), 32'd0);
            check("run_stall", 32'(bus.stall), 32'd1);
            check_hold("run");
            if (c == flush_cyc) begin
               bus.flush = 1'b1;
               @(posedge clk);
               #1;
               bus.flush = 1'b0;
               bus.start = 1'b0;
               #1;
               check("flush_busy", 32'(bus.busy), 32'd0);
               check("flush_done", 32'(bus.done), 32'd0);
               check_hold("flush");
               idle(LAT + 1);
               return;
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_lo = 8'h00;
      exp_hi = 8'h00;
      exp_dz = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.alu_ctrl = 4'h0;
      bus.op_a = 8'h00;
      bus.op_b = 8'h00;
      rst_n = 1'b0;

      // Reset state, with a valid request held during reset.
      @(negedge clk);
      bus.start = 1'b1;
      bus.alu_ctrl = 4'b1010;
      #1;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check_hold("rst");
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Directed cases.
      run_op(1'b0, 8'd13, 8'd11, -1, 1'b0);
      idle(1);
      run_op(1'b0, 8'hFF, 8'hFF, -1, 1'b0);
      run_op(1'b0, 8'h00, 8'hA5, -1, 1'b0);
      idle(2);
      run_op(1'b1, 8'd200, 8'd7, -1, 1'b0);
      run_op(1'b1, 8'd9, 8'd3, -1, 1'b0);
      idle(1);
      run_op(1'b1, 8'h2A, 8'h00, -1, 1'b0);
      idle(1);
`ifdef MULDIV_SIGNED_EN
      run_op(1'b0, 8'hFD, 8'd5, -1, 1'b0);
      run_op(1'b1, 8'hF9, 8'd2, -1, 1'b0);
      run_op(1'b1, 8'h80, 8'hFF, -1, 1'b0);
      idle(1);
`endif

      // Unsupported opcode: no stall, nothing starts.
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.alu_ctrl = 4'b1000;
      bus.op_a = 8'd5;
      bus.op_b = 8'd6;
      #1;
      check("bad_op_stall", 32'(bus.stall), 32'd0);
      idle(LAT + 1);

      // Flush in idle blocks a start.
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.alu_ctrl = 4'b1011;
      #1;
      check("flush_idle_stall", 32'(bus.stall), 32'd0);
      idle(LAT + 1);

      // Start during RUN ignored; flush in cycle 4 aborts with results retained.
      run_op(1'b0, 8'd37, 8'd41, -1, 1'b1);
      run_op(1'b1, 8'd250, 8'd9, 4, 1'b0);

      // Reset in cycle 5 of a run.
      bus.start = 1'b1;
      bus.alu_ctrl = 4'b1010;
      bus.op_a = 8'd13;
      bus.op_b = 8'd11;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      exp_lo = 8'h00;
      exp_hi = 8'h00;
      exp_dz = 1'b0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_stall", 32'(bus.stall), 32'd0);
      check_hold("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(LAT + 2);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         bit dv, inj;
         logic [7:0] a, b;
         int fc;
         dv  = 1'($urandom_range(0, 1));
         a   = 8'($urandom);
         b   = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
         fc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, DATA_W)) : -1;
         inj = ($urandom_range(0, 3) == 0);
         run_op(dv, a, b, fc, inj);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the 8-bit core. It owns the MULTIPLY (ALUControl 4'b1010) and DIVIDE (4'b1011) operations, which are too slow to complete in one cycle. It runs a shift-add multiplier or a restoring divider over DATA_W cycles and asserts `stall` to freeze the pipeline until the result is ready. It sits beside the ALU in the execute stage and is started by the control unit's ALUControl code.

## Interface
- DATA_W, 8, operand/result width. The iteration count equals DATA_W.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- alu_ctrl  in  4  operation select; 4'b1010 = multiply, 4'b1011 = divide; any other value is ignored
- op_a  in  DATA_W  multiplicand / dividend
- op_b  in  DATA_W  multiplier / divisor
- flush  in  1  abort the operation in flight (pipeline flush)
- stall  out  1  freeze pipeline (combinational)
- busy  out  1  registered; high while in RUN
- done  out  1  one-cycle pulse; results valid
- result  out  DATA_W  product low byte / quotient
- result_hi  out  DATA_W  product high byte / remainder
- div_by_zero  out  1  set with done when a divide has op_b == 0

## Operation
- **Accepted request:** start=1 and alu_ctrl ∈ {1010, 1011} while state ∈ {IDLE, DONE}.
  - Operands are latched into internal registers, so later changes to op_a/op_b have no effect.
  - start with any other alu_ctrl: ignored, state unchanged, stall=0.
  - start while in RUN: ignored.
- **States:**
  - IDLE: on an accepted request, go to RUN; for a divide with op_b == 0, go straight to DONE.
  - RUN: a counter loads DATA_W-1 and decrements each cycle. One iteration is performed per cycle. When the counter is 0, go to DONE.
  - DONE: on an accepted request, go to RUN (back-to-back operation); otherwise go to IDLE.
- **Multiply:** unsigned shift-add. The 2·DATA_W product is {result_hi, result}. There is no overflow.
- **Divide:** restoring, unsigned. result = quotient, result_hi = remainder.
- **Divide by zero:** result = all ones, result_hi = op_a, div_by_zero = 1.
- **Output hold:** result, result_hi and div_by_zero update only on entry to DONE. They hold their value until the next entry to DONE.
- **stall** = (state==RUN) | (accepted request this cycle).
  - The pipeline therefore freezes in the issue cycle.
  - stall is 0 in the DONE cycle, so the held instruction retires with the result.
- **flush:** in RUN, return to IDLE on the next edge; no done pulse; outputs unchanged. In IDLE or DONE, flush blocks acceptance of start. flush has priority over start.

## Timing
- **Reset:** async, active-low. Registered outputs clear immediately: busy=0, done=0, result=0, result_hi=0, div_by_zero=0, state=IDLE. stall is combinational and equals 0 while rst_n=0 or start=0.
- **Reset mid-operation:** all state is discarded. After release the block is in IDLE and no done is produced.
- **Normal latency:** request accepted in cycle 0 → busy=1 in cycles 1..DATA_W → done=1 and busy=0 in cycle DATA_W+1 (cycle 9 for DATA_W=8).
- **Divide-by-zero latency:** accepted in cycle 0 → done in cycle 1. busy is never asserted.
- **Back-to-back:** a new request is accepted in the done cycle. The next done follows DATA_W+1 cycles later.
- **Signed mode (with MULDIV_SIGNED_EN):** sign correction is applied on the final transition, so latency is identical to unsigned mode.

## Configuration
- **MULDIV_SIGNED_EN defined:** operands are two's complement.
  - Magnitudes are taken at acceptance and the result signs are fixed when entering DONE.
  - Product: signed 2·DATA_W.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - The most-negative/−1 divide returns quotient = most-negative and remainder = 0.
  - Divide by zero behaves as in unsigned mode.
- **MULDIV_SIGNED_EN undefined:** unsigned only, and no sign logic is synthesized.

## Test plan
- **Multiply:** 13×11 (alu_ctrl=1010, start in cycle 0) → stall=1 in cycles 0..8, busy=1 in cycles 1..8; done in cycle 9 with result=8'h8F, result_hi=8'h00.
- **Multiply extremes:** 8'hFF×8'hFF → {result_hi, result}=16'hFE01. 0×8'hA5 → 16'h0000. Same latency in both cases.
- **Divide:** 200/7 → result=8'h1C, result_hi=8'h04, div_by_zero=0. A new request accepted in the done cycle (9/3) → done in cycle 18 with result=8'h03, result_hi=8'h00.
- **Divide by zero:** 8'h2A/0 → done in cycle 1, result=8'hFF, result_hi=8'h2A, div_by_zero=1; busy never high.
- **Ignored and aborted requests:**
  - start with alu_ctrl=1000 → no stall, no done.
  - start in cycle 3 while in RUN → ignored.
  - flush in cycle 4 → IDLE in cycle 5, no done, previous result retained.
  - rst_n low in cycle 5 of a run → all outputs 0 immediately, no done after release.
- **MULDIV_SIGNED_EN:**
  - (−3)×5 → 16'hFFF1.
  - (−7)/2 → result=8'hFD, result_hi=8'hFF.
  - (−128)/(−1) → result=8'h80, result_hi=8'h00.
  - Latency of 9 cycles in every case.
